// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard buffer: capture-FSM states,
// CPU register offsets and KBDCR bit positions.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        PUSH     = 3'd2,
        ACK      = 3'd3,
        WAIT_LOW = 3'd4
    } cap_state_t;

    localparam logic KBD_OFS   = 1'b0;
    localparam logic KBDCR_OFS = 1'b1;

    localparam int unsigned RDY_BIT = 7;
    localparam int unsigned OVF_BIT = 6;

    // Assemble the KBDCR status byte from its two live flags.
    function automatic logic [7:0] kbdcr_word(input logic rdy, input logic ovf);
        logic [7:0] w;
        w          = 8'h00;
        w[RDY_BIT] = rdy;
        w[OVF_BIT] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/kbd_sync.sv
// Two-flop synchroniser, parameterised width, asynchronous active-high clear.
module kbd_sync #(
    parameter int W = 8
) (
    input  logic         CLOCK_50,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;

    // Both stages clear together so no stale ready bit survives reset.
    always_ff @(posedge CLOCK_50 or posedge clr) begin
        if (clr) begin
            meta_r <= {W{1'b0}};
            q      <= {W{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/kbd_fifo.sv
// PS/2 key-byte capture into a small FIFO, exposed to the CPU as Apple-1
// style KBD / KBDCR read registers with a sticky overflow flag.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int ACK_CYC    = 8
) (
    input  logic       CLOCK_50,
    input  logic       clr,
    input  logic [7:0] key_in,
    output logic       key_ack,
    input  logic       cpu_sel,
    input  logic       cpu_addr,
    input  logic       cpu_rd,
    output logic [7:0] rd_data,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [7:0]    ACK_LAST    = 8'(ACK_CYC - 1);

    logic [7:0]    sk_s;
    cap_state_t    state_r;
    logic [3:0]    settle_cnt_r;
    logic [7:0]    ack_cnt_r;

    logic [6:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          push_s;
    logic          rd_strobe_s;
    logic          empty_s;
    logic          pop_s;
    logic          accept_s;
    logic          drop_s;
    logic          kbdcr_rd_s;
    logic [7:0]    kbdcr_s;

    kbd_sync #(.W(8)) u_sync (
        .CLOCK_50 (CLOCK_50),
        .clr      (clr),
        .d        (key_in),
        .q        (sk_s)
    );

    // Push/pop qualification; a pop in the PUSH cycle frees a slot for it.
    always_comb begin
        push_s      = (state_r == PUSH);
        rd_strobe_s = cpu_sel & cpu_rd;
        empty_s     = (count_r == {CW{1'b0}});
        pop_s       = rd_strobe_s & (cpu_addr == KBD_OFS) & ~empty_s;
        accept_s    = push_s & ((count_r < DEPTH_C) | pop_s);
        drop_s      = push_s & ~accept_s;
        kbdcr_rd_s  = rd_strobe_s & (cpu_addr == KBDCR_OFS);
        kbdcr_s     = kbdcr_word(~empty_s, overflow);
    end

    // Capture FSM: debounce ready, push once, pulse ack, wait for ready to drop.
    always_ff @(posedge CLOCK_50 or posedge clr) begin
        if (clr) begin
            state_r      <= IDLE;
            settle_cnt_r <= 4'd0;
            ack_cnt_r    <= 8'd0;
            key_ack      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    key_ack <= 1'b0;
                    if (sk_s[7]) begin
                        state_r      <= SETTLE;
                        settle_cnt_r <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (!sk_s[7]) begin
                        state_r <= IDLE;
                    end else if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= PUSH;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                PUSH: begin
                    state_r   <= ACK;
                    key_ack   <= 1'b1;
                    ack_cnt_r <= 8'd0;
                end
                ACK: begin
                    if (ack_cnt_r == ACK_LAST) begin
                        state_r <= WAIT_LOW;
                        key_ack <= 1'b0;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + 8'd1;
                    end
                end
                WAIT_LOW: begin
                    key_ack <= 1'b0;
                    if (!sk_s[7]) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    key_ack <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage is deliberately left unreset.
    always_ff @(posedge CLOCK_50) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= sk_s[6:0];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLOCK_50 or posedge clr) begin
        if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a KBDCR read keeps it set.
    always_ff @(posedge CLOCK_50 or posedge clr) begin
        if (clr) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (kbdcr_rd_s) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

    // Read data sampled from pre-edge FIFO state and held between reads.
    always_ff @(posedge CLOCK_50 or posedge clr) begin
        if (clr) begin
            rd_data <= 8'h00;
        end else if (rd_strobe_s) begin
            if (cpu_addr == KBD_OFS) begin
                rd_data <= empty_s ? 8'h00 : {1'b1, mem_r[rd_ptr_r]};
            end else begin
                rd_data <= kbdcr_s;
            end
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: directed scenarios plus a randomized
// key/read mix scored against a queue-based model of the buffer.
module tb_kbd_fifo;

    localparam int DEPTH      = 16;
    localparam int SETTLE_CYC = 4;
    localparam int ACK_CYC    = 8;
    localparam int PUSH_STEP  = SETTLE_CYC + 4;

    logic       CLOCK_50 = 1'b0;
    logic       clr;
    logic [7:0] key_in;
    logic       key_ack;
    logic       cpu_sel;
    logic       cpu_addr;
    logic       cpu_rd;
    logic [7:0] rd_data;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] q_m [$];
    bit         ovf_m = 1'b0;

    kbd_fifo #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC), .ACK_CYC(ACK_CYC)) dut (
        .CLOCK_50 (CLOCK_50),
        .clr      (clr),
        .key_in   (key_in),
        .key_ack  (key_ack),
        .cpu_sel  (cpu_sel),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .rd_data  (rd_data),
        .overflow (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are settled afterwards.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_push(input logic [6:0] code);
        if (q_m.size() < DEPTH) q_m.push_back(code);
        else ovf_m = 1'b1;
    endtask

    // Decoder emulation: raise ready, optionally read KBD in the PUSH cycle,
    // drop ready on ack (or hold it well past ack), check ack timing.
    task automatic send_key(input logic [6:0] code, input bit rd_at_push, input bit hold);
        int         rise;
        int         width;
        logic [7:0] exp_rd;
        rise   = -1;
        width  = 0;
        exp_rd = 8'h00;
        key_in = {1'b1, code};
        for (int i = 1; i <= 36; i++) begin
            if (rd_at_push && i == PUSH_STEP) begin
                cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = 1'b0;
            end
            step();
            if (i == PUSH_STEP) begin
                if (rd_at_push) begin
                    cpu_sel = 1'b0; cpu_rd = 1'b0;
                    exp_rd = (q_m.size() > 0) ? {1'b1, q_m[0]} : 8'h00;
                    if (q_m.size() > 0) void'(q_m.pop_front());
                    check_val("rd_at_push", 32'(rd_data), 32'(exp_rd));
                end
                model_push(code);
            end
            if (key_ack) begin
                if (rise < 0) rise = i;
                width++;
                if (!hold) key_in = 8'h00;
            end
            if (hold && i == 30) key_in = 8'h00;
        end
        check_val("ack_rise", 32'(rise), 32'(PUSH_STEP));
        check_val("ack_width", 32'(width), 32'(ACK_CYC));
        check_val("ovf_pin", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic cpu_read(input logic addr, input string tag);
        logic [7:0] exp;
        cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = addr;
        if (addr == 1'b0) begin
            exp = (q_m.size() > 0) ? {1'b1, q_m[0]} : 8'h00;
            if (q_m.size() > 0) void'(q_m.pop_front());
        end else begin
            exp = {q_m.size() != 0, ovf_m, 6'b000000};
            ovf_m = 1'b0;
        end
        step();
        cpu_sel = 1'b0; cpu_rd = 1'b0;
        check_val(tag, 32'(rd_data), 32'(exp));
        check_val("ovf_pin", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic drain(input string tag);
        int n;
        n = q_m.size();
        for (int i = 0; i < n; i++) cpu_read(1'b0, tag);
        cpu_read(1'b0, "empty_after_drain");
    endtask

    initial begin
        int         seen;
        bit         got_ack;
        logic [7:0] last;

        clr = 1'b1; key_in = 8'h00; cpu_sel = 1'b0; cpu_addr = 1'b0; cpu_rd = 1'b0;
        step(); step();
        check_val("rst_rd_data", 32'(rd_data), 32'h0);
        check_val("rst_key_ack", 32'(key_ack), 32'h0);
        check_val("rst_overflow", 32'(overflow), 32'h0);
        clr = 1'b0;
        step(); step();

        // Single key held past ack: captured exactly once.
        send_key(7'h41, 1'b0, 1'b1);
        cpu_read(1'b1, "kbdcr_one");
        cpu_read(1'b0, "kbd_one");
        last = rd_data;
        step(); step();
        check_val("rd_hold", 32'(rd_data), 32'(last));
        cpu_read(1'b1, "kbdcr_empty");

        // Short ready glitch: never captured.
        got_ack = 1'b0;
        key_in = 8'h85;
        step(); step();
        key_in = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_ack) got_ack = 1'b1;
        end
        check_val("glitch_ack", 32'(got_ack), 32'h0);
        cpu_read(1'b1, "glitch_kbdcr");

        // Seventeen keys into a sixteen-deep FIFO.
        for (int k = 0; k < 17; k++) send_key(7'(8'hB1 + k), 1'b0, 1'b0);
        cpu_read(1'b1, "ovf_kbdcr");
        cpu_read(1'b1, "ovf_cleared");
        drain("ovf_drain");

        // Full FIFO with a KBD read in the PUSH cycle.
        for (int k = 0; k < DEPTH; k++) send_key(7'($urandom_range(0, 127)), 1'b0, 1'b0);
        send_key(7'h5A, 1'b1, 1'b0);
        cpu_read(1'b1, "full_pop_kbdcr");
        drain("wrap_drain");

        // Empty read, then a single push.
        cpu_read(1'b0, "empty_kbd");
        cpu_read(1'b1, "empty_kbdcr");
        send_key(7'h20, 1'b0, 1'b0);
        cpu_read(1'b0, "kbd_a0");

        // Reset in the middle of an ack pulse with three entries queued.
        for (int k = 0; k < 3; k++) send_key(7'(8'h61 + k), 1'b0, 1'b0);
        key_in = 8'h9A;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            step();
            if (key_ack) seen = i + 1;
        end
        check_val("ack_before_clr", 32'(seen != 0), 32'h1);
        step(); step();
        clr = 1'b1;
        #1;
        check_val("clr_key_ack", 32'(key_ack), 32'h0);
        key_in = 8'h00;
        step(); step();
        clr = 1'b0;
        q_m.delete();
        ovf_m = 1'b0;
        step();
        cpu_read(1'b1, "clr_kbdcr");
        send_key(7'h0D, 1'b0, 1'b0);
        cpu_read(1'b0, "kbd_8d");

        // Randomized mix of keys and register reads.
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) send_key(7'($urandom_range(0, 127)), $urandom_range(0, 3) == 0, 1'b0);
            else if (r < 8) cpu_read(1'b0, "rnd_kbd");
            else cpu_read(1'b1, "rnd_kbdcr");
        end
        cpu_read(1'b1, "rnd_final_kbdcr");
        drain("rnd_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kbd_fifo.md
# kbd_fifo

Keyboard buffer between the PS/2 scan-code decoder and the CPU bus. Takes the decoder's strobed key byte (bit 7 = key ready, bits 6:0 = 7-bit Apple-style code), synchronises it into the CLOCK_50 domain, and queues it in a small FIFO. It acknowledges the decoder so the decoder can clear its ready bit. It exposes Apple-1-style KBD/KBDCR read registers to the CPU.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..64.
- SETTLE_CYC, 4, CLOCK_50 cycles key_in must stay ready before capture; 1..15.
- ACK_CYC, 8, width of key_ack pulse in CLOCK_50 cycles; 1..255.
- CLOCK_50  in  1  system clock.
- clr  in  1  reset, asynchronous, active-high.
- key_in  in  8  decoder output, asynchronous to CLOCK_50; bit 7 = ready, 6:0 = code.
- key_ack  out  1  drives the decoder's ready-clear input; high for ACK_CYC cycles per accepted byte.
- cpu_sel  in  1  register block selected.
- cpu_addr  in  1  0 = KBD, 1 = KBDCR.
- cpu_rd  in  1  one-cycle read strobe, qualified by cpu_sel.
- rd_data  out  8  registered read data.
- overflow  out  1  sticky overflow flag; also KBDCR bit 6.

## Operation
- key_in passes through a 2-flop synchroniser (all 8 bits). Logic uses only the synchronised copy sk.
- Capture FSM has 5 states:
  - IDLE: sk[7]=1 → SETTLE, counter cleared.
  - SETTLE: sk[7]=0 → IDLE, treated as a glitch. Otherwise the counter increments; when it reaches SETTLE_CYC-1 → PUSH.
  - PUSH: one cycle. Write sk[6:0] if accepted (see below), then → ACK.
  - ACK: key_ack=1 for ACK_CYC cycles, then → WAIT_LOW.
  - WAIT_LOW: key_ack=0. sk[7]=0 → IDLE.
- A byte is pushed only once per ready assertion. A ready bit that is still high after ACK is not re-captured.
- Push acceptance: accepted if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped, overflow is set, and ACK still proceeds so the decoder is released.
- Pop: occurs when cpu_sel & cpu_rd & cpu_addr=0 & count>0.
- Simultaneous push and pop: both take effect and count is unchanged. When empty, a pop has no effect (no underflow).
- Read data:
  - KBD: {1, head[6:0]} when non-empty, 8'h00 when empty.
  - KBDCR: {~empty, overflow, 6'b0}. A KBDCR read clears overflow on the same edge it is sampled. An overflow set in that same cycle wins, so overflow stays 1.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (clr high, async):
  - FSM goes to IDLE.
  - Pointers, count, overflow, rd_data and key_ack all go to 0; synchroniser flops go to 0.
  - FIFO storage is not reset.
  - Asserting clr mid-ACK drops key_ack immediately.

## Timing
- Define edge 0 as the first CLOCK_50 rising edge at which key_in[7]=1 is sampled.
  - sk[7]=1 after edge 1.
  - FSM enters SETTLE at edge 2 and PUSH at edge 2+SETTLE_CYC.
  - The FIFO write and the count increment occur at edge 3+SETTLE_CYC.
  - key_ack rises at edge 3+SETTLE_CYC and stays high for exactly ACK_CYC cycles.
- rd_data is updated on the edge where cpu_sel&cpu_rd=1, using pre-edge FIFO state. It holds at all other times. Read latency is 1 cycle.
- A pop and the new head are visible to a KBD read on the next cycle.
- No combinational path from key_in or the cpu_* inputs to any output.

## Structure
- Package kbd_pkg holds:
  - the capture state enum (IDLE, SETTLE, PUSH, ACK, WAIT_LOW);
  - the register offsets KBD_OFS=0 and KBDCR_OFS=1;
  - the KBDCR bit positions RDY_BIT=7 and OVF_BIT=6.
- One sub-module, kbd_sync: a parameterised-width 2-flop synchroniser with async clear, instantiated with width 8.
- FIFO storage is an inferred register array in kbd_fifo.

## Test plan
- key_in=8'hC1 held → exactly one entry, key_ack high ACK_CYC cycles starting edge 3+SETTLE_CYC; KBDCR read=8'h80, KBD read=8'hC1, then KBDCR=8'h00.
- key_in[7] high for 2 cycles only (< SETTLE_CYC) → no push, key_ack never rises, KBDCR stays 8'h00.
- 17 keys (8'hB1..8'hC1) with no reads, DEPTH=16 → 16 stored, 17th dropped, overflow=1, KBDCR=8'hC0; the KBDCR read clears it; KBD reads return 8'hB1..8'hC0 in order.
- FIFO full, KBD read in the same cycle as PUSH → push accepted, count stays 16, overflow=0; pointer wrap verified by reading all 16 entries back in order.
- KBD read while empty → rd_data=8'h00, count stays 0; then push 8'hA0 → read gives 8'hA0.
- clr asserted during ACK with 3 entries queued → key_ack=0, KBDCR=8'h00 immediately after release; next key 8'h8D is captured normally and reads back 8'h8D.
